// File: rtl/data_mem_responder.sv
// Data-bus memory responder: word-organised RAM serving one byte/halfword/word
// access per MREQ, with a fixed wait-state count and a one-cycle low ACKD_n.
module data_mem_responder #(
    parameter int          ADDR_W      = 10,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
    parameter int          WAIT_CYCLES = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] DAD,
    input  logic        MREQ,
    input  logic        WRITE,
    input  logic [1:0]  SIZE,
    inout  wire  [31:0] DDT,
    output logic        ACKD_n,
    output logic        busy,
    output logic        err
);
    localparam int DEPTH = 2 ** ADDR_W;

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ACK} state_t;

    state_t            state, state_nxt;
    logic [3:0]        cnt, cnt_nxt;
    logic              enter_ack;

    logic [31:0]       addr_q, wdata_q, rdata_q;
    logic [1:0]        size_q;
    logic              write_q, fault_q;

    logic [31:0]       cur_addr, cur_wdata;
    logic [1:0]        cur_size;
    logic              cur_write, cur_fault;
    logic [32:0]       span_end;
    logic [ADDR_W-1:0] idx;
    logic [4:0]        lane_sh;
    logic [3:0]        be;
    logic [31:0]       bmask, mem_word, merged, rd_sh, rd_sel;

    logic [31:0]       mem [DEPTH];

    // With zero wait states the commit happens on the sampling edge itself,
    // so the live bus is used in IDLE and the latched copy afterwards.
    always_comb begin
        cur_addr  = (state == S_IDLE) ? DAD   : addr_q;
        cur_wdata = (state == S_IDLE) ? DDT   : wdata_q;
        cur_size  = (state == S_IDLE) ? SIZE  : size_q;
        cur_write = (state == S_IDLE) ? WRITE : write_q;
    end

    always_comb begin
        span_end  = {1'b0, BASE_ADDR} + (33'd1 << (ADDR_W + 2));
        idx       = ADDR_W'(32'(cur_addr - BASE_ADDR) >> 2);
        cur_fault = (cur_addr < BASE_ADDR) || ({1'b0, cur_addr} >= span_end)
                  || (cur_size == 2'b11)
                  || (cur_size == 2'b01 && cur_addr[0])
                  || (cur_size == 2'b00 && cur_addr[1:0] != 2'b00);
    end

    // Lane math assumes a non-faulted access, which is always naturally aligned.
    always_comb begin
        lane_sh  = {cur_addr[1:0], 3'b000};
        case (cur_size)
            2'b00:   be = 4'b1111;
            2'b01:   be = 4'b0011 << cur_addr[1:0];
            default: be = 4'b0001 << cur_addr[1:0];
        endcase
        bmask    = {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
        mem_word = mem[idx];
        merged   = (mem_word & ~bmask) | ((cur_wdata << lane_sh) & bmask);
        rd_sh    = mem_word >> lane_sh;
        case (cur_size)
            2'b00:   rd_sel = rd_sh;
            2'b01:   rd_sel = {16'b0, rd_sh[15:0]};
            default: rd_sel = {24'b0, rd_sh[7:0]};
        endcase
        if (cur_fault) rd_sel = 32'b0;
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        enter_ack = 1'b0;
        case (state)
            S_IDLE: if (MREQ) begin
                if (WAIT_CYCLES == 0) begin
                    state_nxt = S_ACK;
                    enter_ack = 1'b1;
                end else begin
                    state_nxt = S_WAIT;
                    cnt_nxt   = 4'(WAIT_CYCLES - 1);
                end
            end
            S_WAIT: if (cnt == 4'd0) begin
                state_nxt = S_ACK;
                enter_ack = 1'b1;
            end else begin
                cnt_nxt = cnt - 4'd1;
            end
            S_ACK:   state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= S_IDLE;
            cnt     <= 4'd0;
            addr_q  <= 32'b0;
            wdata_q <= 32'b0;
            size_q  <= 2'b0;
            write_q <= 1'b0;
            fault_q <= 1'b0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            if (state == S_IDLE && MREQ) begin
                addr_q  <= DAD;
                wdata_q <= DDT;
                size_q  <= SIZE;
                write_q <= WRITE;
                fault_q <= cur_fault;
            end
        end
    end

    // RAM is not reset; reset held low blocks any commit on that edge.
    always_ff @(posedge clk) begin
        if (enter_ack && rst) begin
            if (cur_write && !cur_fault) mem[idx] <= merged;
            rdata_q <= rd_sel;
        end
    end

    assign ACKD_n = (state != S_ACK);
    assign busy   = (state != S_IDLE);
    assign err    = (state == S_ACK) && fault_q;
    assign DDT    = (state == S_ACK && !write_q) ? rdata_q : 32'hz;

endmodule
